// File: rtl/dcm_ctrl.sv
// Divider-change controller: round-robin arbitration between two requesters,
// update pulse, settle wait, ack. Optional DCM_CTRL_SKIP_SAME_EN skips no-op codes.
module dcm_ctrl #(
  parameter int unsigned SETTLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [2:0] prog_a,
  input  logic       req_b,
  input  logic [2:0] prog_b,
  output logic       update,
  output logic [2:0] prog_out,
  output logic       ack_a,
  output logic       ack_b,
  output logic       busy,
  output logic [2:0] cur_prog
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_ACK
  } state_t;

  localparam logic [7:0] LOAD = 8'(SETTLE - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_win;
  logic       r_last;
  logic [2:0] r_code;
  logic [2:0] r_cur;
  logic [7:0] r_cnt;

  logic       w_req;
  logic       w_win;
  logic [2:0] w_code;
  logic       w_skip;

  // r_win/r_last: 0 = A, 1 = B
  assign w_req  = req_a | req_b;
  assign w_win  = (req_a & req_b) ? ~r_last : req_b;
  assign w_code = w_win ? prog_b : prog_a;

`ifdef DCM_CTRL_SKIP_SAME_EN
  assign w_skip = (w_code == r_cur);
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_req) w_next = w_skip ? S_ACK : S_ISSUE;
      S_ISSUE:  w_next = S_SETTLE;
      S_SETTLE: if (r_cnt == 8'd0) w_next = S_ACK;
      S_ACK:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_win   <= 1'b0;
      r_last  <= 1'b1;
      r_code  <= 3'd0;
      r_cur   <= 3'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_win  <= w_win;
            r_code <= w_code;
          end
        end
        S_ISSUE: begin
          r_cur <= r_code;
          r_cnt <= LOAD;
        end
        S_SETTLE: begin
          if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        end
        S_ACK: r_last <= r_win;
        default: ;
      endcase
    end
  end

  assign update   = (r_state == S_ISSUE);
  assign prog_out = r_code;
  assign ack_a    = (r_state == S_ACK) & ~r_win;
  assign ack_b    = (r_state == S_ACK) & r_win;
  assign busy     = (r_state != S_IDLE);
  assign cur_prog = r_cur;

endmodule
